uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 107 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Optional feature: UART_ARB_PRIO_EN (requester 0 has fixed priority).
package uart_tx_arbiter_pkg;

  localparam int unsigned LEN_W   = 32;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  // The transmitter can never send more bytes than the payload holds.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input int unsigned      max_len);
    return (len > LEN_W'(max_len)) ? LEN_W'(max_len) : len;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DATA_MAX_LEN = 4
);
  localparam int unsigned DATA_W = DATA_MAX_LEN * 8;

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ*LEN_W-1:0]  req_len;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic                    busy;
  logic [DATA_W-1:0]       tx_data;
  logic [LEN_W-1:0]        tx_len;
  logic                    tx_send;
  logic                    tx_ready;

  modport slave (
    input  req, req_data, req_len, tx_ready,
    output gnt, done, busy, tx_data, tx_len, tx_send
  );

  modport master (
    output req, req_data, req_len, tx_ready,
    input  gnt, done, busy, tx_data, tx_len, tx_send
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]                                 req_i,
  input  logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0]     ptr_i,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0]     idx_c_o,
  output logic                                             valid_c_o
);
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  always_comb begin
    int unsigned pos;
    pos       = 0;
    idx_c_o   = '0;
    valid_c_o = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = (32'(ptr_i) + k) % N_REQ;
      if (!valid_c_o && req_i[PTR_W'(pos)]) begin
        valid_c_o = 1'b1;
        idx_c_o   = PTR_W'(pos);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter handing one UART transmitter to N_REQ requesters.
// Define UART_ARB_PRIO_EN to give requester 0 fixed priority over the ring.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DATA_MAX_LEN = 4
) (
  input logic              clk,
  input logic              res,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned DATA_W = DATA_MAX_LEN * 8;
`ifdef UART_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [LEN_W-1:0]   tx_len_q, tx_len_d;

  logic [PTR_W-1:0]   rr_idx_c;
  logic               rr_vld_c;
  logic [PTR_W-1:0]   sel_idx_c;
  logic [LEN_W-1:0]   sel_len_c;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .idx_c_o   (rr_idx_c),
    .valid_c_o (rr_vld_c)
  );

  // Requester 0 overrides the ring only when priority is compiled in.
  assign sel_idx_c = (PRIO_EN && bus.req[0]) ? '0 : rr_idx_c;
  assign sel_len_c = bus.req_len[sel_idx_c*LEN_W +: LEN_W];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    gnt_d     = '0;
    done_d    = '0;
    tx_data_d = tx_data_q;
    tx_len_d  = tx_len_q;
    case (state_q)
      S_IDLE: begin
        if (rr_vld_c && bus.tx_ready) begin
          win_d            = sel_idx_c;
          gnt_d[sel_idx_c] = 1'b1;
          tx_data_d        = bus.req_data[sel_idx_c*DATA_W +: DATA_W];
          tx_len_d         = clamp_len(sel_len_c, DATA_MAX_LEN);
          // Empty frames bypass the transmitter and complete immediately.
          state_d          = (sel_len_c == '0) ? S_WAIT_DONE : S_SEND;
        end
      end
      S_SEND: state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!bus.tx_ready) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus.tx_ready) begin
          done_d[win_q] = 1'b1;
          if (!(PRIO_EN && win_q == '0)) begin
            ptr_d = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + PTR_W'(1);
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      tx_data_q <= '0;
      tx_len_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      tx_data_q <= tx_data_d;
      tx_len_q  <= tx_len_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.tx_send = (state_q == S_SEND);
  assign bus.tx_data = tx_data_q;
  assign bus.tx_len  = tx_len_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a bit-level UART transmitter model.
// Honours UART_ARB_PRIO_EN in its reference model.
module tb_uart_tx_arbiter;
  localparam int N     = 4;
  localparam int DML   = 4;
  localparam int CYCLE = 10;
`ifdef UART_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [31:0] len;
  } exp_t;

  logic clk = 1'b0;
  logic res;
  logic force_busy;
  int   cyc = 0;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_MAX_LEN(DML)) bus ();
  uart_tx_arbiter #(.N_REQ(N), .DATA_MAX_LEN(DML)) dut (.clk(clk), .res(res), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter: CYCLE clocks per bit, 1 start, 8 data LSB first, 1 stop.
  logic tx_active;
  logic tx_line;
  logic [7:0] cur_byte;
  int tx_cnt, bit_idx, byte_idx, nbytes;

  always @(posedge clk or posedge res) begin
    if (res) begin
      tx_active <= 1'b0; tx_cnt <= 0; bit_idx <= 0; byte_idx <= 0; nbytes <= 0;
    end else if (!tx_active) begin
      if (bus.tx_send) begin
        tx_active <= 1'b1; tx_cnt <= 0; bit_idx <= 0; byte_idx <= 0;
        nbytes <= int'(bus.tx_len);
      end
    end else if (tx_cnt != CYCLE - 1) begin
      tx_cnt <= tx_cnt + 1;
    end else begin
      tx_cnt <= 0;
      if (bit_idx != 9) bit_idx <= bit_idx + 1;
      else begin
        bit_idx <= 0;
        if (byte_idx >= nbytes - 1) tx_active <= 1'b0;
        else byte_idx <= byte_idx + 1;
      end
    end
  end

  always_comb begin
    cur_byte = bus.tx_data[byte_idx*8 +: 8];
    tx_line  = 1'b1;
    if (tx_active) begin
      if (bit_idx == 0) tx_line = 1'b0;
      else if (bit_idx <= 8) tx_line = cur_byte[bit_idx-1];
    end
  end

  assign bus.tx_ready = !tx_active && !force_busy;

  // Scoreboard state and reference model
  exp_t        exp_gnt_q[$];
  int          exp_done_q[$];
  logic [9:0]  exp_frame_q[$];
  int          m_ptr = 0;
  logic [31:0] m_data [N];
  logic [31:0] m_len  [N];
  int n_checks = 0, n_pass = 0;
  int gnt_seen = 0, done_seen = 0;
  bit lat_armed = 1'b0;
  int lat_cyc = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic int model_pick(input bit pend [N]);
    if (PRIO && pend[0]) return 0;
    for (int k = 0; k < N; k++)
      if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return 0;
  endfunction

  // Expected grants, frames and completions for one burst of requests.
  task automatic predict(input logic [N-1:0] mask, input bit hold, input int n_grants);
    bit pend [N];
    for (int i = 0; i < N; i++) pend[i] = mask[i];
    for (int g = 0; g < n_grants; g++) begin
      int w, nb;
      exp_t e;
      w  = model_pick(pend);
      nb = (m_len[w] > 32'(DML)) ? DML : int'(m_len[w]);
      e.idx = w; e.data = m_data[w]; e.len = 32'(nb);
      exp_gnt_q.push_back(e);
      for (int b = 0; b < nb; b++) exp_frame_q.push_back({1'b1, m_data[w][b*8 +: 8], 1'b0});
      exp_done_q.push_back(w);
      if (!(PRIO && w == 0)) m_ptr = (w + 1) % N;
      if (!hold) pend[w] = 1'b0;
    end
  endtask

  // Grant / done monitor
  initial begin
    exp_t cur;
    int   gnt_cyc;
    cur.idx = 0; cur.data = '0; cur.len = '0; gnt_cyc = 0;
    forever begin
      @(negedge clk);
      if (!res) begin
        if (bus.tx_send) chk("tx_send_needs_ready", 64'(bus.tx_ready), 64'd1);
        if (bus.done != '0) begin
          done_seen++;
          if (exp_done_q.size() == 0) chk("unexpected_done", 64'(bus.done), 64'd0);
          else begin
            int w;
            w = exp_done_q.pop_front();
            chk("done_onehot", 64'(bus.done), 64'(1) << w);
            chk("tx_data_stable", 64'(bus.tx_data), 64'(cur.data));
            chk("tx_len_stable", 64'(bus.tx_len), 64'(cur.len));
            if (cur.len == 0) chk("zero_len_done_latency", 64'(cyc), 64'(gnt_cyc + 1));
          end
        end
        if (bus.gnt != '0) begin
          gnt_seen++;
          if (lat_armed) begin
            chk("gnt_latency", 64'(cyc), 64'(lat_cyc));
            lat_armed = 1'b0;
          end
          if (exp_gnt_q.size() == 0) chk("unexpected_gnt", 64'(bus.gnt), 64'd0);
          else begin
            cur = exp_gnt_q.pop_front();
            gnt_cyc = cyc;
            chk("gnt_onehot", 64'(bus.gnt), 64'(1) << cur.idx);
            chk("tx_data_latched", 64'(bus.tx_data), 64'(cur.data));
            chk("tx_len_latched", 64'(bus.tx_len), 64'(cur.len));
            chk("tx_send_with_gnt", 64'(bus.tx_send), 64'(cur.len != 0));
          end
        end
      end
    end
  end

  // Line monitor: sample mid-bit, compare each completed 10-bit frame
  initial begin
    logic [9:0] frame_bits;
    frame_bits = '0;
    forever begin
      @(negedge clk);
      if (!res && tx_active && tx_cnt == CYCLE / 2 - 1) begin
        frame_bits[bit_idx] = tx_line;
        if (bit_idx == 9) begin
          if (exp_frame_q.size() == 0) chk("unexpected_frame", 64'(frame_bits), 64'd0);
          else chk("line_frame", 64'(frame_bits), 64'(exp_frame_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic rand_slots();
    for (int i = 0; i < N; i++) begin
      m_data[i] = $urandom();
      m_len[i]  = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 9));
    end
  endtask

  task automatic load_slots();
    for (int i = 0; i < N; i++) begin
      bus.req_data[i*32 +: 32] = m_data[i];
      bus.req_len[i*32 +: 32]  = m_len[i];
    end
  endtask

  // A requester withdraws after its grant and is free to change its payload.
  task automatic release_req(input int w);
    bus.req[w] = 1'b0;
    bus.req_data[w*32 +: 32] = $urandom();
    bus.req_len[w*32 +: 32]  = 32'($urandom_range(0, 15));
  endtask

  task automatic run_phase(input logic [N-1:0] mask, input bit hold, input int n_grants,
                           input int stall);
    int seen, budget, g0;
    predict(mask, hold, n_grants);
    @(negedge clk);
    load_slots();
    if (stall > 0) begin
      force_busy = 1'b1;
      bus.req = mask;
      g0 = gnt_seen;
      repeat (stall) @(negedge clk);
      chk("no_gnt_while_tx_busy", 64'(gnt_seen), 64'(g0));
      force_busy = 1'b0;
    end
    bus.req = mask;
    lat_cyc = cyc + 1;
    lat_armed = 1'b1;
    seen = 0;
    budget = n_grants * 600 + 100;
    while (budget > 0 && !(seen == n_grants && exp_done_q.size() == 0 && !bus.busy)) begin
      @(negedge clk);
      budget--;
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) begin
          seen++;
          if (!hold) release_req(i);
          else if (seen == n_grants) bus.req = '0;
        end
      end
    end
    chk("phase_grant_count", 64'(seen), 64'(n_grants));
    chk("phase_done_drained", 64'(exp_done_q.size()), 64'd0);
    if (budget == 0) begin
      bus.req = '0;
      exp_gnt_q.delete(); exp_done_q.delete(); exp_frame_q.delete();
      lat_armed = 1'b0;
    end
  endtask

  initial begin
    int budget, d0;
    logic [N-1:0] mask;
    res = 1'b1;
    force_busy = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    bus.req_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_tx_send", 64'(bus.tx_send), 64'd0);
    chk("rst_tx_data", 64'(bus.tx_data), 64'd0);
    chk("rst_tx_len", 64'(bus.tx_len), 64'd0);
    res = 1'b0;

    // All four held high: ring order from ptr 0, one byte each
    rand_slots();
    for (int i = 0; i < N; i++) m_len[i] = 32'd1;
    run_phase(4'b1111, 1'b1, 5, 0);

    // Single byte 0x55 on requester 0
    rand_slots(); m_data[0] = 32'h55; m_len[0] = 32'd1;
    run_phase(4'b0001, 1'b0, 1, 0);

    // Zero-length frame on requester 2, then a full ring to expose ptr
    rand_slots(); m_len[2] = 32'd0;
    run_phase(4'b0100, 1'b0, 1, 0);
    rand_slots();
    run_phase(4'b1111, 1'b0, 4, 0);

    // Over-long length on requester 1 is clamped
    rand_slots(); m_len[1] = 32'd9;
    run_phase(4'b0010, 1'b0, 1, 0);

    // Transmitter busy while idle: no grant until it is ready again
    rand_slots(); m_len[0] = 32'd2;
    run_phase(4'b0001, 1'b0, 1, 12);

    // ptr parked on 2, then requesters 0 and 2 together
    rand_slots(); m_len[1] = 32'd1;
    run_phase(4'b0010, 1'b0, 1, 0);
    rand_slots(); m_len[0] = 32'd1; m_len[2] = 32'd1;
    run_phase(4'b0101, 1'b0, 2, 0);

    // Reset while waiting for the transmitter to finish
    rand_slots(); m_len[3] = 32'd2;
    predict(4'b1000, 1'b0, 1);
    @(negedge clk);
    load_slots();
    bus.req = 4'b1000;
    lat_cyc = cyc + 1;
    lat_armed = 1'b1;
    budget = 50;
    while (budget > 0 && !bus.gnt[3]) begin @(negedge clk); budget--; end
    release_req(3);
    budget = 50;
    while (budget > 0 && bus.tx_ready) begin @(negedge clk); budget--; end
    repeat (5) @(negedge clk);
    chk("busy_before_reset", 64'(bus.busy), 64'd1);
    #2 res = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_tx_len", 64'(bus.tx_len), 64'd0);
    exp_gnt_q.delete(); exp_done_q.delete(); exp_frame_q.delete();
    m_ptr = 0;
    lat_armed = 1'b0;
    @(negedge clk);
    res = 1'b0;
    d0 = done_seen;
    repeat (30) @(negedge clk);
    chk("no_done_after_reset", 64'(done_seen), 64'(d0));
    rand_slots();
    run_phase(4'b1111, 1'b0, 4, 0);

    // Randomised bursts
    repeat (25) begin
      rand_slots();
      mask = 4'($urandom_range(1, 15));
      run_phase(mask, 1'b0, $countones(mask), 0);
    end

    repeat (5) @(negedge clk);
    chk("leftover_gnt_expectations", 64'(exp_gnt_q.size()), 64'd0);
    chk("leftover_frame_expectations", 64'(exp_frame_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
